binary_maxpool: RTL and testbench
=================================

# binary_maxpool

- Downstream stage of the binary XNOR-convolution engine.
- Reads binary feature maps produced by the convolution stage from its input SRAM, applies 2x2, stride-2 max pooling (a logical OR on binary data), and writes the pooled maps to its output SRAM.
- Processes a sequence of images until a sentinel header, using the same run/busy control and SRAM handshake as the convolution stage.

## Interface
- Parameters:
- `DATA_W`, 16, SRAM word width; one image row per word, LSB-aligned.
- `ADDR_W`, 12, SRAM address width.
- Ports:
- `clk` in 1: the single clock; all logic on the rising edge.
- `reset_b` in 1: reset is synchronous and active-low.
- `dut_run` in 1: start pulse, sampled only in IDLE.
- `dut_busy` out 1: high from the cycle after start until the sequence completes.
- `dut_sram_read_address` out `ADDR_W`: input SRAM address, registered.
- `sram_dut_read_data` in `DATA_W`: input SRAM data, valid one cycle after its address.
- `dut_sram_write_address` out `ADDR_W`: output SRAM address.
- `dut_sram_write_data` out `DATA_W`: output SRAM data.
- `dut_sram_write_enable` out 1: write strobe, one word per high cycle.

## Operation
- Input format, repeated per image:
  - One header word; `N = header[4:0]`, where N is one of 8, 10 or 14.
  - Then N row words; bit c of row r is pixel (r, c).
  - A header equal to 16'h00FF ends the sequence.
  - Any other header value also ends the sequence, exactly like the sentinel.
- Pooling: output row p (p < N/2), bit j (j < N/2) = `row[2p][2j] | row[2p][2j+1] | row[2p+1][2j] | row[2p+1][2j+1]`.
  - Bits at positions N/2 and above are 0.
  - Input bits at positions N and above are ignored.
- FSM states:
  - S_IDLE: on `dut_run` -> S_HDR.
  - S_HDR: issue the header read. On valid header data, a valid N -> S_ROWS; the sentinel or an invalid header -> S_DONE.
  - S_ROWS: issue N row reads on consecutive cycles, then the next header read back-to-back -> S_HDR.
  - S_DONE: drain the final write, then -> S_IDLE.
- Addressing:
  - The read address increments by 1 per issued read and is contiguous across images.
  - The write address starts at 0, increments after every write, and is contiguous across images.
  - Both addresses return to 0 on entry to S_IDLE.
- `dut_run` asserted while busy is ignored.
- Reset (including mid-image): abandon work, go to S_IDLE, all outputs to reset values. No partial-row write is issued after reset.

## Timing
- Reset values: `dut_busy` 0, `dut_sram_write_enable` 0, both addresses 0, `dut_sram_write_data` 0.
- Start:
  - Cycle T: `dut_run` high in S_IDLE.
  - T+1: `dut_busy`=1; read address 0 is presented.
  - T+2: header data is valid and decoded.
  - T+3: address 1 is presented.
- Row reads: one per cycle with no bubbles inside an image.
- Write latency: `dut_sram_write_enable` pulses for exactly one cycle, in the cycle after row 2p+1 data is valid. Sustained rate is one write per 2 cycles.
- End of sequence:
  - Cycle A: the last row of the last image is addressed.
  - A+1: the sentinel header is addressed.
  - A+2: the sentinel data is valid and the last pooled write occurs.
  - A+3: `dut_busy` falls.
- If the sentinel is the first header, no writes occur and `dut_busy` is high for exactly 2 cycles (T+1 and T+2).

## Configuration
- Macro `BMP_HEADER_WRITE_EN`.
- Defined:
  - Each output image is preceded by a header word holding N/2, written in the cycle after the header data is valid.
  - After the sentinel, one 16'h00FF word is written; `dut_busy` falls one cycle later than without the macro.
  - Output format then matches the input format, so stages can be cascaded.
- Undefined: only pooled rows are written, contiguously, with no header and no terminator.

## Structure
- Package `bmp_pkg`:
  - State encoding (one-hot, 4 states).
  - `SENTINEL` = 16'h00FF.
  - Legal N constants 8, 10 and 14.
  - Function mapping a header to a valid flag.
- Sub-module `pool_cell`: a combinational 4-input OR producing one output bit, instantiated 7 times in a generate loop. Pipeline and FSM stay in the top level.

## Test plan
- One 8x8 image, all rows 16'h00FF, then sentinel -> four writes of 16'h000F at addresses 0-3 (with the macro: 16'h0004 at 0, rows at 1-4, 16'h00FF at 5).
- 14x14 image, only pixel (13,13) set -> output row 6 = 16'h0040, rows 0-5 = 0.
- 10x10 checkerboard (0x155 / 0x2AA rows) -> five rows of 16'h001F; bits 5-15 zero.
- 8x8 image followed by 12x12 (invalid) -> four writes, then busy falls as for a sentinel; no writes from the second image.
- Back-to-back 8x8 and 10x10 images -> write addresses 0-8 contiguous (macro off); read addresses contiguous with no idle cycle between images.
- `reset_b` low during row 5 of a 14x14 image -> next cycle busy 0, write enable 0, addresses 0; a new `dut_run` restarts from address 0.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared types and constants for the binary max-pool stage: one-hot state
// encoding, sentinel word, legal image sizes and the header decode helper.
package bmp_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_HDR  = 4'b0010,
    S_ROWS = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  localparam logic [15:0] SENTINEL   = 16'h00FF;
  localparam logic [4:0]  N_8        = 5'd8;
  localparam logic [4:0]  N_10       = 5'd10;
  localparam logic [4:0]  N_14       = 5'd14;
  localparam int          POOL_CELLS = 7;

  // Only 8, 10 and 14 are legal sizes; the sentinel and anything else end the run.
  function automatic logic hdr_valid(input logic [15:0] hdr);
    logic [4:0] n;
    n = hdr[4:0];
    return (hdr != SENTINEL) && ((n == N_8) || (n == N_10) || (n == N_14));
  endfunction

endpackage

// File: rtl/pool_cell.sv
// One output pixel of the 2x2 binary max pool: OR of two adjacent bits from
// an even row and the two bits below them in the following odd row.
module pool_cell (
  input  logic [1:0] i_top,
  input  logic [1:0] i_bot,
  output logic       o_pool
);

  assign o_pool = |{i_top, i_bot};

endmodule

// File: rtl/binary_maxpool.sv
// 2x2 stride-2 binary max pool between input and output SRAMs, image after image
// until a sentinel/invalid header. Macro BMP_HEADER_WRITE_EN adds output headers and terminator.
module binary_maxpool
  import bmp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  // state  | meaning
  // S_IDLE | waiting for dut_run, addresses at 0
  // S_HDR  | header address presented, then header decoded one cycle later
  // S_ROWS | N row reads on consecutive cycles
  // S_DONE | final write drains, addresses cleared

  state_t                  r_state, w_state_nxt;
  logic                    r_hdr_v;
  logic [4:0]              r_n, r_row_cnt;
  logic [ADDR_W-1:0]       r_rd_addr, r_wr_addr;
  logic                    r_dv, r_dodd;
  logic [2*POOL_CELLS-1:0] r_even;
  logic                    r_wr_en;
  logic [DATA_W-1:0]       r_wr_data;

  logic                    w_hdr_ok, w_last_row;
  logic [POOL_CELLS-1:0]   w_pool, w_mask;
  logic [DATA_W-1:0]       w_wr_row;

  for (genvar j = 0; j < POOL_CELLS; j++) begin : g_pool
    pool_cell u_cell (
      .i_top  (r_even[2*j+1:2*j]),
      .i_bot  (sram_dut_read_data[2*j+1:2*j]),
      .o_pool (w_pool[j])
    );
  end

  always_comb begin
    for (int j = 0; j < POOL_CELLS; j++) begin
      w_mask[j] = (5'(2*j) < r_n);
    end
    w_wr_row = DATA_W'(w_pool & w_mask);
  end

  always_ff @(posedge clk) begin
    if (!reset_b) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_ok    = hdr_valid(sram_dut_read_data[15:0]);
    w_last_row  = (r_row_cnt == r_n - 5'd1);
`ifdef BMP_HEADER_WRITE_EN
    dut_busy    = (r_state != S_IDLE);
`else
    dut_busy    = (r_state == S_HDR) || (r_state == S_ROWS);
`endif
    case (r_state)
      S_IDLE:  if (dut_run) w_state_nxt = S_HDR;
      S_HDR:   if (r_hdr_v) w_state_nxt = w_hdr_ok ? S_ROWS : S_DONE;
      S_ROWS:  if (w_last_row) w_state_nxt = S_HDR;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_hdr_v   <= 1'b0;
      r_n       <= '0;
      r_row_cnt <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_dv      <= 1'b0;
      r_dodd    <= 1'b0;
      r_even    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_hdr_v <= (r_state == S_HDR) && !r_hdr_v;
      r_dv    <= (r_state == S_ROWS);
      r_dodd  <= r_row_cnt[0];
      r_wr_en <= 1'b0;
      if (r_wr_en) r_wr_addr <= r_wr_addr + ADDR_W'(1);
      if (r_dv && !r_dodd) r_even <= sram_dut_read_data[2*POOL_CELLS-1:0];
      // Odd-row data completes a pooled row; it is written on the following cycle.
      if (r_dv && r_dodd) begin
        r_wr_en   <= 1'b1;
        r_wr_data <= w_wr_row;
      end
      case (r_state)
        S_HDR: begin
          if (r_hdr_v && w_hdr_ok) begin
            r_n       <= sram_dut_read_data[4:0];
            r_row_cnt <= '0;
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
`ifdef BMP_HEADER_WRITE_EN
            r_wr_en   <= 1'b1;
            r_wr_data <= DATA_W'(sram_dut_read_data[4:1]);
`endif
          end
`ifdef BMP_HEADER_WRITE_EN
          else if (r_hdr_v) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= DATA_W'(SENTINEL);
          end
`endif
        end
        S_ROWS: begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
          r_row_cnt <= r_row_cnt + 5'd1;
        end
        S_DONE: begin
          r_rd_addr <= '0;
          r_wr_addr <= '0;
        end
        default: ;
      endcase
    end
  end

  assign dut_sram_read_address  = r_rd_addr;
  assign dut_sram_write_address = r_wr_addr;
  assign dut_sram_write_data    = r_wr_data;
  assign dut_sram_write_enable  = r_wr_en;

endmodule

// File: tb/tb_binary_maxpool.sv
// Self-checking bench for binary_maxpool: a cycle-indexed expectation table built
// from the image list in the input SRAM, compared against the DUT every cycle.
module tb_binary_maxpool;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int MAXK   = 512;
`ifdef BMP_HEADER_WRITE_EN
  localparam int HOFS = 1;
`else
  localparam int HOFS = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic              dut_run = 1'b0;
  logic              dut_busy;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] rdata, wdata;
  logic              we;

  binary_maxpool #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (raddr),
    .sram_dut_read_data     (rdata),
    .dut_sram_write_address (waddr),
    .dut_sram_write_data    (wdata),
    .dut_sram_write_enable  (we)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_in  [0:4095];
  logic [15:0] out_mem [0:4095];
  always @(posedge clk) rdata <= mem_in[raddr];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_k    = 0;
  int          wp       = 0;
  int          n_wr     = 0;
  int          last_k   = 0;
  int          exp_ra   [MAXK];
  bit          exp_busy [MAXK];
  bit          exp_we   [MAXK];
  int          exp_wa   [MAXK];
  logic [15:0] exp_wd   [MAXK];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cur_k, act, exp);
    end
  endtask

  task automatic put(input logic [15:0] w);
    mem_in[wp] = w;
    wp++;
  endtask

  task automatic put_random_img(input int n);
    put(16'(n));
    for (int r = 0; r < n; r++) put(16'($urandom));
  endtask

  // Walk the input image list with the documented timing: header issued at k,
  // decoded at k+1, rows addressed k+2..k+N+1, pooled row p written at k+5+2p.
  task automatic build_expect();
    int a, k, wa, n, rb;
    logic [15:0] hdr, ra, rb0, pw;
    bit ok;
    for (int i = 0; i < MAXK; i++) begin
      exp_ra[i] = -1; exp_busy[i] = 0; exp_we[i] = 0; exp_wa[i] = 0; exp_wd[i] = '0;
    end
    a = 0; k = 1; wa = 0;
    forever begin
      hdr = mem_in[a];
      n   = int'(hdr[4:0]);
      ok  = (hdr != 16'h00FF) && (n == 8 || n == 10 || n == 14);
      exp_ra[k] = a;
      exp_busy[k] = 1; exp_busy[k+1] = 1;
      if (!ok) begin
`ifdef BMP_HEADER_WRITE_EN
        exp_busy[k+2] = 1; exp_we[k+2] = 1; exp_wa[k+2] = wa; exp_wd[k+2] = 16'h00FF;
`endif
        last_k = k + 2;
        break;
      end
`ifdef BMP_HEADER_WRITE_EN
      exp_we[k+2] = 1; exp_wa[k+2] = wa; exp_wd[k+2] = 16'(n / 2); wa++;
`endif
      for (int r = 0; r < n; r++) begin
        exp_ra[k+2+r] = a + 1 + r;
        exp_busy[k+2+r] = 1;
      end
      for (int p = 0; p < n / 2; p++) begin
        ra  = mem_in[a + 1 + 2*p];
        rb0 = mem_in[a + 2 + 2*p];
        pw  = '0;
        for (int j = 0; j < n / 2; j++) begin
          rb = 2 * j;
          pw[j] = ra[rb] | ra[rb+1] | rb0[rb] | rb0[rb+1];
        end
        exp_we[k+5+2*p] = 1; exp_wa[k+5+2*p] = wa; exp_wd[k+5+2*p] = pw; wa++;
      end
      a += n + 1;
      k += n + 2;
    end
  endtask

  // Start at the cycle after the call, compare every cycle; optional stray run
  // pulse while busy and optional reset at cycle rst_k.
  task automatic run_seq(input int run_k, input int rst_k);
    build_expect();
    for (int i = 0; i < 4096; i++) out_mem[i] = '0;
    n_wr = 0;
    @(negedge clk);
    dut_run = 1'b1;
    for (int k = 1; k <= last_k + 2; k++) begin
      @(negedge clk);
      cur_k   = k;
      dut_run = (k == run_k);
      check("busy", int'(dut_busy), int'(exp_busy[k]));
      check("write_enable", int'(we), int'(exp_we[k]));
      if (exp_we[k]) begin
        check("write_address", int'(waddr), exp_wa[k]);
        check("write_data", int'(wdata), int'(exp_wd[k]));
      end
      if (we) begin
        out_mem[waddr] = wdata;
        n_wr++;
      end
      if (exp_ra[k] >= 0) check("read_address", int'(raddr), exp_ra[k]);
      if (k == rst_k) begin
        reset_b = 1'b0;
        break;
      end
    end
    dut_run = 1'b0;
    if (rst_k > 0) begin
      @(negedge clk);
      cur_k = rst_k + 1;
      reset_b = 1'b1;
      check("rst_busy", int'(dut_busy), 0);
      check("rst_write_enable", int'(we), 0);
      check("rst_read_address", int'(raddr), 0);
      check("rst_write_address", int'(waddr), 0);
      repeat (4) begin
        @(negedge clk);
        cur_k++;
        check("post_rst_write_enable", int'(we), 0);
        check("post_rst_busy", int'(dut_busy), 0);
      end
    end
  endtask

  initial begin
    int cnt, sel;
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(dut_busy), 0);
    check("reset_write_enable", int'(we), 0);
    check("reset_read_address", int'(raddr), 0);
    check("reset_write_address", int'(waddr), 0);
    check("reset_write_data", int'(wdata), 0);
    reset_b = 1'b1;
    @(negedge clk);

    // 8x8 of 0x00FF rows
    wp = 0; put(16'd8);
    for (int r = 0; r < 8; r++) put(16'h00FF);
    put(16'h00FF);
    run_seq(0, 0);
    for (int p = 0; p < 4; p++) check("t1_row", int'(out_mem[HOFS+p]), 16'h000F);
`ifdef BMP_HEADER_WRITE_EN
    check("t1_hdr", int'(out_mem[0]), 16'h0004);
    check("t1_term", int'(out_mem[5]), 16'h00FF);
`endif

    // 14x14 with only pixel (13,13)
    wp = 0; put(16'd14);
    for (int r = 0; r < 13; r++) put(16'h0000);
    put(16'h2000);
    put(16'h00FF);
    run_seq(0, 0);
    check("t2_row6", int'(out_mem[HOFS+6]), 16'h0040);
    check("t2_row0", int'(out_mem[HOFS+0]), 16'h0000);
    check("t2_row5", int'(out_mem[HOFS+5]), 16'h0000);

    // 10x10 checkerboard
    wp = 0; put(16'd10);
    for (int r = 0; r < 10; r++) put((r % 2 == 0) ? 16'h0155 : 16'h02AA);
    put(16'h00FF);
    run_seq(0, 0);
    for (int p = 0; p < 5; p++) check("t3_row", int'(out_mem[HOFS+p]), 16'h001F);

    // 8x8 then an invalid 12x12 header
    wp = 0; put_random_img(8); put(16'd12);
    for (int r = 0; r < 12; r++) put(16'hFFFF);
    run_seq(0, 0);
    check("t4_write_count", n_wr, 4 + 2*HOFS);

    // back-to-back 8x8 and 10x10
    wp = 0; put_random_img(8); put_random_img(10); put(16'h00FF);
    run_seq(0, 0);
    check("t5_write_count", n_wr, 9 + 3*HOFS);

    // sentinel as the first header
    wp = 0; put(16'h00FF);
    run_seq(0, 0);
    check("t6_write_count", n_wr, HOFS);

    // reset during row 5 of a 14x14 image, then a clean restart
    wp = 0; put_random_img(14); put(16'h00FF);
    run_seq(0, 7);
    wp = 0; put_random_img(10); put(16'h00FF);
    run_seq(0, 0);

    // random image sequences with a stray run pulse while busy
    for (int it = 0; it < 6; it++) begin
      wp  = 0;
      cnt = $urandom_range(1, 4);
      for (int i = 0; i < cnt; i++) begin
        sel = $urandom_range(0, 2);
        put_random_img(sel == 0 ? 8 : (sel == 1 ? 10 : 14));
      end
      put(16'h00FF);
      run_seq($urandom_range(2, 6), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
